// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory line-request arbiter.
package mem_arb_pkg;

    localparam int unsigned AW_DEFAULT = 32;
    localparam int unsigned DW_DEFAULT = 128;
    localparam int unsigned MW_DEFAULT = DW_DEFAULT / 8;

    localparam logic REQ_UART = 1'b0;
    localparam logic REQ_DC   = 1'b1;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWaitW = 2'd2,
        StWaitR = 2'd3
    } arb_state_e;

endpackage

// File: rtl/arb_req_hold.sv
// Per-requester capture of write/read request pulses: pending bits, hold registers and a
// sticky overflow flag for pulses that arrive while the same request type is still pending.
module arb_req_hold #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 128,
    parameter int unsigned MW = 16
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          wstart_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [MW-1:0] wmask_i,
    input  logic          rstart_i,
    input  logic [AW-1:0] raddr_i,
    input  logic          wclr_i,
    input  logic          rclr_i,
    output logic          wpend_o,
    output logic          rpend_o,
    output logic [AW-1:0] waddr_o,
    output logic [DW-1:0] wdata_o,
    output logic [MW-1:0] wmask_o,
    output logic [AW-1:0] raddr_o,
    output logic          ovf_o
);

    logic          wpend_q, wpend_d;
    logic          rpend_q, rpend_d;
    logic          ovf_q, ovf_d;
    logic [AW-1:0] waddr_q;
    logic [DW-1:0] wdata_q;
    logic [MW-1:0] wmask_q;
    logic [AW-1:0] raddr_q;
    logic          w_accept;
    logic          r_accept;

    // A slot being cleared this cycle is free again, so a coinciding pulse is taken.
    assign w_accept = wstart_i && (!wpend_q || wclr_i);
    assign r_accept = rstart_i && (!rpend_q || rclr_i);

    always_comb begin
        wpend_d = wpend_q;
        rpend_d = rpend_q;
        if (wclr_i) wpend_d = 1'b0;
        if (w_accept) wpend_d = 1'b1;
        if (rclr_i) rpend_d = 1'b0;
        if (r_accept) rpend_d = 1'b1;
        ovf_d = ovf_q | (wstart_i && !w_accept) | (rstart_i && !r_accept);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wpend_q <= 1'b0;
            rpend_q <= 1'b0;
            ovf_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            raddr_q <= '0;
        end else begin
            wpend_q <= wpend_d;
            rpend_q <= rpend_d;
            ovf_q   <= ovf_d;
            if (w_accept) begin
                waddr_q <= waddr_i;
                wdata_q <= wdata_i;
                wmask_q <= wmask_i;
            end
            if (r_accept) raddr_q <= raddr_i;
        end
    end

    assign wpend_o = wpend_q;
    assign rpend_o = rpend_q;
    assign waddr_o = waddr_q;
    assign wdata_o = wdata_q;
    assign wmask_o = wmask_q;
    assign raddr_o = raddr_q;
    assign ovf_o   = ovf_q;

endmodule

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter granting the single line-request port to the UART loader or the
// data-cache engine, one transaction at a time, and routing completions back to the owner.
module mem_req_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW = AW_DEFAULT,
    parameter int unsigned DW = DW_DEFAULT,
    parameter int unsigned MW = MW_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      req_wstart_rq,
    input  logic [2*AW-1:0] req_win_addr,
    input  logic [2*DW-1:0] req_in_wdata,
    input  logic [2*MW-1:0] req_in_mask,
    output logic [1:0]      req_finish_wresp,
    input  logic [1:0]      req_rstart_rq,
    input  logic [2*AW-1:0] req_rin_addr,
    output logic [DW-1:0]   req_rdat_data,
    output logic [1:0]      req_rdat_valid,
    output logic [1:0]      req_finish_mrd,
    output logic [1:0]      ovf_err,
    output logic            m_wstart_rq,
    output logic [AW-1:0]   m_win_addr,
    output logic [DW-1:0]   m_in_wdata,
    output logic [MW-1:0]   m_in_mask,
    input  logic            m_finish_wresp,
    output logic            m_rstart_rq,
    output logic [AW-1:0]   m_rin_addr,
    input  logic [DW-1:0]   m_rdat_data,
    input  logic            m_rdat_valid,
    input  logic            m_finish_mrd,
    output logic            busy,
    output logic            grant_id
);

    arb_state_e    state_q, state_d;
    logic          grant_q, grant_d;
    logic          op_rd_q, op_rd_d;
    logic          rr_last_q, rr_last_d;
    logic          sel;
    logic          load;
    logic [1:0]    wpend, rpend, pend;
    logic [1:0]    wclr, rclr;
    logic [1:0]    ovf;
    logic [AW-1:0] h_waddr [2];
    logic [DW-1:0] h_wdata [2];
    logic [MW-1:0] h_wmask [2];
    logic [AW-1:0] h_raddr [2];
    logic [AW-1:0] m_waddr_q, m_raddr_q;
    logic [DW-1:0] m_wdata_q;
    logic [MW-1:0] m_wmask_q;
    logic [1:0]    owner;
    logic [1:0]    fw_q, rv_q, fr_q;
    logic [DW-1:0] rdat_q;

    for (genvar i = 0; i < 2; i++) begin : g_hold
        arb_req_hold #(
            .AW(AW),
            .DW(DW),
            .MW(MW)
        ) u_hold (
            .clk_i    (clk),
            .rst_ni   (rst_n),
            .wstart_i (req_wstart_rq[i]),
            .waddr_i  (req_win_addr[i*AW +: AW]),
            .wdata_i  (req_in_wdata[i*DW +: DW]),
            .wmask_i  (req_in_mask[i*MW +: MW]),
            .rstart_i (req_rstart_rq[i]),
            .raddr_i  (req_rin_addr[i*AW +: AW]),
            .wclr_i   (wclr[i]),
            .rclr_i   (rclr[i]),
            .wpend_o  (wpend[i]),
            .rpend_o  (rpend[i]),
            .waddr_o  (h_waddr[i]),
            .wdata_o  (h_wdata[i]),
            .wmask_o  (h_wmask[i]),
            .raddr_o  (h_raddr[i]),
            .ovf_o    (ovf[i])
        );
    end

    assign pend  = wpend | rpend;
    assign owner = grant_q ? 2'b10 : 2'b01;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        op_rd_d   = op_rd_q;
        rr_last_d = rr_last_q;
        wclr      = 2'b00;
        rclr      = 2'b00;
        load      = 1'b0;
        // The requester that was not served last has priority.
        sel       = pend[~rr_last_q] ? ~rr_last_q : rr_last_q;
        unique case (state_q)
            StIdle: begin
                if (|pend) begin
                    grant_d = sel;
                    op_rd_d = ~wpend[sel];
                    load    = 1'b1;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (op_rd_q) begin
                    rclr[grant_q] = 1'b1;
                    state_d       = StWaitR;
                end else begin
                    wclr[grant_q] = 1'b1;
                    state_d       = StWaitW;
                end
            end
            StWaitW: begin
                if (m_finish_wresp) begin
                    rr_last_d = grant_q;
                    state_d   = StIdle;
                end
            end
            StWaitR: begin
                if (m_finish_mrd) begin
                    rr_last_d = grant_q;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            grant_q   <= REQ_UART;
            op_rd_q   <= 1'b0;
            rr_last_q <= REQ_DC;
            m_waddr_q <= '0;
            m_wdata_q <= '0;
            m_wmask_q <= '0;
            m_raddr_q <= '0;
            fw_q      <= 2'b00;
            rv_q      <= 2'b00;
            fr_q      <= 2'b00;
            rdat_q    <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            op_rd_q   <= op_rd_d;
            rr_last_q <= rr_last_d;
            // Snapshot at selection so a re-captured hold cannot disturb the live request.
            if (load) begin
                m_waddr_q <= h_waddr[sel];
                m_wdata_q <= h_wdata[sel];
                m_wmask_q <= h_wmask[sel];
                m_raddr_q <= h_raddr[sel];
            end
            fw_q <= (state_q == StWaitW && m_finish_wresp) ? owner : 2'b00;
            rv_q <= (state_q == StWaitR && m_rdat_valid) ? owner : 2'b00;
            fr_q <= (state_q == StWaitR && m_finish_mrd) ? owner : 2'b00;
            if (state_q == StWaitR && m_rdat_valid) rdat_q <= m_rdat_data;
        end
    end

    assign m_wstart_rq      = (state_q == StIssue) && !op_rd_q;
    assign m_rstart_rq      = (state_q == StIssue) && op_rd_q;
    assign m_win_addr       = m_waddr_q;
    assign m_in_wdata       = m_wdata_q;
    assign m_in_mask        = m_wmask_q;
    assign m_rin_addr       = m_raddr_q;
    assign req_finish_wresp = fw_q;
    assign req_rdat_valid   = rv_q;
    assign req_finish_mrd   = fr_q;
    assign req_rdat_data    = rdat_q;
    assign ovf_err          = ovf;
    assign busy             = (state_q != StIdle);
    assign grant_id         = grant_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Self-checking bench for mem_req_arbiter: a cycle-by-cycle vector table for arbitration and
// handshakes, then hand-written sequences for data paths, overflow and asynchronous reset.
module tb_mem_req_arbiter;

    localparam int AW = 32;
    localparam int DW = 128;
    localparam int MW = 16;

    logic            clk;
    logic            rst_n;
    logic [1:0]      req_wstart_rq;
    logic [2*AW-1:0] req_win_addr;
    logic [2*DW-1:0] req_in_wdata;
    logic [2*MW-1:0] req_in_mask;
    logic [1:0]      req_finish_wresp;
    logic [1:0]      req_rstart_rq;
    logic [2*AW-1:0] req_rin_addr;
    logic [DW-1:0]   req_rdat_data;
    logic [1:0]      req_rdat_valid;
    logic [1:0]      req_finish_mrd;
    logic [1:0]      ovf_err;
    logic            m_wstart_rq;
    logic [AW-1:0]   m_win_addr;
    logic [DW-1:0]   m_in_wdata;
    logic [MW-1:0]   m_in_mask;
    logic            m_finish_wresp;
    logic            m_rstart_rq;
    logic [AW-1:0]   m_rin_addr;
    logic [DW-1:0]   m_rdat_data;
    logic            m_rdat_valid;
    logic            m_finish_mrd;
    logic            busy;
    logic            grant_id;

    int errors = 0;
    int checks = 0;

    mem_req_arbiter #(
        .AW(AW),
        .DW(DW),
        .MW(MW)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_wstart_rq    (req_wstart_rq),
        .req_win_addr     (req_win_addr),
        .req_in_wdata     (req_in_wdata),
        .req_in_mask      (req_in_mask),
        .req_finish_wresp (req_finish_wresp),
        .req_rstart_rq    (req_rstart_rq),
        .req_rin_addr     (req_rin_addr),
        .req_rdat_data    (req_rdat_data),
        .req_rdat_valid   (req_rdat_valid),
        .req_finish_mrd   (req_finish_mrd),
        .ovf_err          (ovf_err),
        .m_wstart_rq      (m_wstart_rq),
        .m_win_addr       (m_win_addr),
        .m_in_wdata       (m_in_wdata),
        .m_in_mask        (m_in_mask),
        .m_finish_wresp   (m_finish_wresp),
        .m_rstart_rq      (m_rstart_rq),
        .m_rin_addr       (m_rin_addr),
        .m_rdat_data      (m_rdat_data),
        .m_rdat_valid     (m_rdat_valid),
        .m_finish_mrd     (m_finish_mrd),
        .busy             (busy),
        .grant_id         (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs applied in one cycle; expected outputs observed in the following cycle.
    typedef struct packed {
        logic [1:0] ws;
        logic [1:0] rs;
        logic       mfw;
        logic       mrv;
        logic       mfr;
        logic       mws;
        logic       mrs;
        logic [1:0] fw;
        logic [1:0] rv;
        logic [1:0] fr;
        logic       bsy;
        logic       gid;
    } vec_t;

    localparam int NVEC = 27;
    vec_t tbl [NVEC];

    function automatic vec_t mk(logic [1:0] ws, logic [1:0] rs, logic mfw, logic mrv,
                                logic mfr, logic mws, logic mrs, logic [1:0] fw,
                                logic [1:0] rv, logic [1:0] fr, logic bsy, logic gid);
        vec_t v;
        v.ws = ws; v.rs = rs; v.mfw = mfw; v.mrv = mrv; v.mfr = mfr;
        v.mws = mws; v.mrs = mrs; v.fw = fw; v.rv = rv; v.fr = fr; v.bsy = bsy; v.gid = gid;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_pulses();
        req_wstart_rq  = 2'b00;
        req_rstart_rq  = 2'b00;
        m_finish_wresp = 1'b0;
        m_rdat_valid   = 1'b0;
        m_finish_mrd   = 1'b0;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_pulses();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // {m_wstart, m_rstart, finish_wresp, rdat_valid, finish_mrd, ovf, busy, grant}
    function automatic logic [11:0] ctl();
        return {m_wstart_rq, m_rstart_rq, req_finish_wresp, req_rdat_valid, req_finish_mrd,
                ovf_err, busy, grant_id};
    endfunction

    initial begin
        rst_n        = 1'b0;
        req_win_addr = '0;
        req_in_wdata = '0;
        req_in_mask  = '0;
        req_rin_addr = '0;
        m_rdat_data  = '0;
        clear_pulses();

        //            ws     rs     mfw   mrv   mfr   mws   mrs   fw     rv     fr     bsy   gid
        tbl[0]  = mk(2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        tbl[1]  = mk(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
        tbl[2]  = mk(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
        tbl[3]  = mk(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0);
        tbl[4]  = mk(2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        tbl[5]  = mk(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1);
        tbl[6]  = mk(2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1);
        tbl[7]  = mk(2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b10, 2'b10, 1'b0, 1'b1);
        tbl[8]  = mk(2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
        tbl[9]  = mk(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
        tbl[10] = mk(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
        tbl[11] = mk(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0);
        tbl[12] = mk(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1);
        tbl[13] = mk(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1);
        tbl[14] = mk(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 1'b0, 1'b1);
        tbl[15] = mk(2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
        tbl[16] = mk(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
        tbl[17] = mk(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
        tbl[18] = mk(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0);
        tbl[19] = mk(2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        tbl[20] = mk(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1);
        tbl[21] = mk(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1);
        tbl[22] = mk(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 1'b0, 1'b1);
        tbl[23] = mk(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
        tbl[24] = mk(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
        tbl[25] = mk(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0);
        tbl[26] = mk(2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);

        do_reset();
        chk("reset_ctl", 128'(ctl()), 128'd0);
        chk("reset_rdat", req_rdat_data, 128'd0);
        chk("reset_maddr", {m_win_addr, m_rin_addr}, 128'd0);

        for (int i = 0; i < NVEC; i++) begin
            req_wstart_rq  = tbl[i].ws;
            req_rstart_rq  = tbl[i].rs;
            m_finish_wresp = tbl[i].mfw;
            m_rdat_valid   = tbl[i].mrv;
            m_finish_mrd   = tbl[i].mfr;
            step();
            clear_pulses();
            chk($sformatf("vec%0d", i), 128'(ctl()),
                128'({tbl[i].mws, tbl[i].mrs, tbl[i].fw, tbl[i].rv, tbl[i].fr, 2'b00,
                      tbl[i].bsy, tbl[i].gid}));
        end

        // Requester 0 write, full field check and latency.
        do_reset();
        req_win_addr[31:0]  = 32'h0000_1000;
        req_in_wdata[127:0] = {16{8'hA5}};
        req_in_mask[15:0]   = 16'hFFFF;
        req_wstart_rq       = 2'b01;
        step();
        clear_pulses();
        chk("w0_pend_not_issued", m_wstart_rq, 1'b0);
        step();
        chk("w0_wstart", m_wstart_rq, 1'b1);
        chk("w0_addr", m_win_addr, 32'h0000_1000);
        chk("w0_data", m_in_wdata, {16{8'hA5}});
        chk("w0_mask", m_in_mask, 16'hFFFF);
        req_win_addr[31:0] = 32'hDEAD_0000;
        repeat (3) step();
        chk("w0_addr_stable", m_win_addr, 32'h0000_1000);
        chk("w0_wstart_once", m_wstart_rq, 1'b0);
        step();
        m_finish_wresp = 1'b1;
        step();
        clear_pulses();
        chk("w0_finish", req_finish_wresp, 2'b01);
        chk("w0_busy_low", busy, 1'b0);

        // Requester 1 read with data and finish in the same beat.
        req_rin_addr[63:32] = 32'h0000_2040;
        req_rstart_rq       = 2'b10;
        step();
        clear_pulses();
        step();
        chk("r1_rstart", m_rstart_rq, 1'b1);
        chk("r1_addr", m_rin_addr, 32'h0000_2040);
        step();
        m_rdat_data  = {8{16'h1234}};
        m_rdat_valid = 1'b1;
        m_finish_mrd = 1'b1;
        step();
        clear_pulses();
        chk("r1_data", req_rdat_data, {8{16'h1234}});
        chk("r1_valid", req_rdat_valid, 2'b10);
        chk("r1_finish", req_finish_mrd, 2'b10);

        // Requester 0 write+read together; re-capture of the write during ISSUE.
        req_win_addr[31:0] = 32'h0000_3000;
        req_rin_addr[31:0] = 32'h0000_3100;
        req_wstart_rq      = 2'b01;
        req_rstart_rq      = 2'b01;
        step();
        clear_pulses();
        step();
        chk("wr_first_ctl", {m_wstart_rq, m_rstart_rq}, 2'b10);
        chk("wr_first_addr", m_win_addr, 32'h0000_3000);
        req_win_addr[31:0] = 32'h0000_3300;
        req_wstart_rq      = 2'b01;
        step();
        clear_pulses();
        chk("issue_recapture_no_ovf", ovf_err, 2'b00);
        m_finish_wresp = 1'b1;
        step();
        clear_pulses();
        chk("wr_w1_finish", req_finish_wresp, 2'b01);
        step();
        chk("wr_second_w_ctl", {m_wstart_rq, m_rstart_rq}, 2'b10);
        chk("wr_second_w_addr", m_win_addr, 32'h0000_3300);
        step();
        m_finish_wresp = 1'b1;
        step();
        clear_pulses();
        chk("wr_w2_finish", req_finish_wresp, 2'b01);
        step();
        chk("wr_read_ctl", {m_wstart_rq, m_rstart_rq}, 2'b01);
        chk("wr_read_addr", m_rin_addr, 32'h0000_3100);
        step();
        m_finish_mrd = 1'b1;
        step();
        clear_pulses();
        chk("wr_read_finish", {req_finish_mrd, req_rdat_valid}, 4'b0100);

        // Overflow: second write from requester 1 while its first is pending.
        req_win_addr[63:32] = 32'h0000_4000;
        req_wstart_rq       = 2'b10;
        step();
        req_win_addr[63:32] = 32'h0000_4444;
        step();
        clear_pulses();
        chk("ovf_set", ovf_err, 2'b10);
        chk("ovf_orig_addr", m_win_addr, 32'h0000_4000);
        chk("ovf_issue", {m_wstart_rq, grant_id}, 2'b11);
        step();
        m_finish_wresp = 1'b1;
        step();
        clear_pulses();
        chk("ovf_finish", req_finish_wresp, 2'b10);
        chk("ovf_sticky", ovf_err, 2'b10);
        step();
        chk("ovf_dropped", busy, 1'b0);

        // Asynchronous reset in WAIT_R, then a late finish.
        req_rin_addr[31:0] = 32'h0000_5000;
        req_rstart_rq      = 2'b01;
        step();
        clear_pulses();
        repeat (2) step();
        m_rdat_data  = {4{32'hCAFE_F00D}};
        m_rdat_valid = 1'b1;
        step();
        clear_pulses();
        chk("rst_pre_valid", {req_rdat_valid, busy}, 3'b011);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_ctl", 128'(ctl()), 128'd0);
        chk("rst_async_rdat", req_rdat_data, 128'd0);
        step();
        rst_n        = 1'b1;
        m_finish_mrd = 1'b1;
        step();
        clear_pulses();
        chk("rst_late_finish", 128'(ctl()), 128'd0);
        step();
        chk("rst_idle", {busy, m_rstart_rq}, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
